// File: rtl/fp_ci_issuer.sv
// rtl/fp_ci_issuer.sv - FIFO-buffered issuer of operand pairs to a multicycle FP custom-instruction unit
// Optional watchdog: define FP_CI_ISSUER_TIMEOUT_EN to compile in the WAIT-state timeout.
module fp_ci_issuer #(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_dataa,
  input  logic [31:0] in_datab,
  output logic [31:0] ci_dataa,
  output logic [31:0] ci_datab,
  output logic        ci_start,
  input  logic        ci_done,
  input  logic [31:0] ci_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        busy,
  output logic        timeout
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("fp_ci_issuer: DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  state_t        state, state_nxt;
  logic [31:0]   mem_a [DEPTH];
  logic [31:0]   mem_b [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop, fifo_empty;
  logic          load_ops, capture, release_out, timeout_fire;

  assign in_ready   = (count != FULL_CNT);
  assign fifo_empty = (count == '0);
  assign push       = in_valid && in_ready;
  assign busy       = (state != IDLE) || !fifo_empty;

  // FIFO storage; contents are don't-care while empty so no reset is needed
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= in_dataa;
      mem_b[wr_ptr] <= in_datab;
    end
  end

  // FIFO pointers wrap naturally at the power-of-two depth; count tracks occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and control strobes; operands are loaded on the edge entering ISSUE
  always_comb begin
    state_nxt   = state;
    ci_start    = 1'b0;
    pop         = 1'b0;
    load_ops    = 1'b0;
    capture     = 1'b0;
    release_out = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          state_nxt = ISSUE;
          load_ops  = 1'b1;
        end
      end
      ISSUE: begin
        ci_start  = 1'b1;
        pop       = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (ci_done) begin
          capture   = 1'b1;
          state_nxt = HOLD;
        end else if (timeout_fire) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (out_valid && out_ready) begin
          release_out = 1'b1;
          if (!fifo_empty) begin
            state_nxt = ISSUE;
            load_ops  = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand and result registers; a real result takes priority over the watchdog
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ci_dataa   <= '0;
      ci_datab   <= '0;
      out_result <= '0;
      out_valid  <= 1'b0;
    end else begin
      if (load_ops) begin
        ci_dataa <= mem_a[rd_ptr];
        ci_datab <= mem_b[rd_ptr];
      end
      if (capture) begin
        out_result <= ci_result;
        out_valid  <= 1'b1;
      end else if (timeout_fire) begin
        out_result <= 32'h7FC0_0000;
        out_valid  <= 1'b1;
      end else if (release_out) begin
        out_valid  <= 1'b0;
      end
    end
  end

`ifdef FP_CI_ISSUER_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] wait_cnt;
  logic          timeout_q;

  assign timeout_fire = (state == WAIT) && !ci_done && (wait_cnt == LAST_WAIT);
  assign timeout      = timeout_q;

  // Count WAIT cycles (held at zero elsewhere); timeout flag is sticky until reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state != WAIT)               wait_cnt <= '0;
      else if (wait_cnt != LAST_WAIT)  wait_cnt <= wait_cnt + 1'b1;
      if (timeout_fire) timeout_q <= 1'b1;
    end
  end
`else
  assign timeout_fire = 1'b0;
  assign timeout      = 1'b0;
`endif

endmodule

// File: doc/fp_ci_issuer.md
FP_CI_ISSUER -- requirements
Module: fp_ci_issuer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4: operand-pair FIFO depth, a power of two, at least 2.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 1024: watchdog limit in cycles, used only when the watchdog is compiled in.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, all state on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: an operand pair is offered.
REQ-006 The block SHALL have port in_ready, output, 1 bit: FIFO not full.
REQ-007 The block SHALL have ports in_dataa and in_datab, input, 32 bits each: IEEE-754 single operands.
REQ-008 The block SHALL have ports ci_dataa and ci_datab, output, 32 bits each: operands driven to the multicycle FP unit.
REQ-009 The block SHALL have port ci_start, output, 1 bit: one-cycle start pulse to the FP unit.
REQ-010 The block SHALL have port ci_done, input, 1 bit: FP unit result valid.
REQ-011 The block SHALL have port ci_result, input, 32 bits: FP unit result.
REQ-012 The block SHALL have port out_valid, output, 1 bit: out_result holds an unconsumed result.
REQ-013 The block SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-014 The block SHALL have port out_result, output, 32 bits: captured result.
REQ-015 The block SHALL have port busy, output, 1 bit: state is not IDLE, or the FIFO is not empty.
REQ-016 The block SHALL have port timeout, output, 1 bit: sticky watchdog flag.

Function
REQ-017 Pair accepted on clk edge with in_valid && in_ready; in_ready SHALL be low when FIFO holds DEPTH entries, even if a pop occurs that cycle.
REQ-018 FIFO pointers SHALL wrap modulo DEPTH; occupancy counter 0..DEPTH; a simultaneous push and pop SHALL leave the count unchanged.
REQ-019 FSM states SHALL be IDLE, ISSUE, WAIT, HOLD.
REQ-020 IDLE SHALL go to ISSUE when the FIFO is non-empty; otherwise it stays in IDLE.
REQ-021 ISSUE SHALL last exactly one cycle with ci_start=1, FIFO head loaded to ci_dataa/ci_datab, and head popped; then go to WAIT.
REQ-022 ci_dataa/ci_datab SHALL stay stable from ISSUE until leaving WAIT; ci_start SHALL be 0 in every other state.
REQ-023 In WAIT, ci_done=1 SHALL capture ci_result into out_result, set out_valid=1 on the same edge, and go to HOLD.
REQ-024 ci_done SHALL be ignored outside WAIT, including during the ISSUE cycle and late arrivals.
REQ-025 In HOLD, out_valid && out_ready SHALL clear out_valid; next state SHALL be ISSUE if the FIFO is non-empty, else IDLE.
REQ-026 Latency: with the block in IDLE and FIFO empty, accepting a pair at edge E0 SHALL assert ci_start in the cycle after edge E1; out_valid SHALL rise on the edge that samples ci_done in WAIT.
REQ-027 Results SHALL be delivered in acceptance order, one pair outstanding at the FP unit at a time.

Reset
REQ-028 Asserting reset SHALL immediately force state IDLE, FIFO empty, and ci_start, out_valid, timeout, ci_dataa, ci_datab, out_result all 0; busy 0; in_ready 1.
REQ-029 Reset mid-operation SHALL abandon queued and in-flight pairs; a ci_done arriving after reset release SHALL be ignored (state IDLE).

Configuration
REQ-030 With FP_CI_ISSUER_TIMEOUT_EN defined, a WAIT cycle counter SHALL clear on entering WAIT; if it reaches TIMEOUT_CYCLES without ci_done, the block SHALL load out_result=32'h7FC00000, set out_valid and timeout (sticky until reset), and go to HOLD.
REQ-031 Without FP_CI_ISSUER_TIMEOUT_EN, WAIT SHALL wait indefinitely, no counter SHALL exist, and timeout SHALL be tied to 0 (port retained).

Verification
REQ-032 Scenario 1: push (3F800000, 40000000), unit returns 40400000 after 10 cycles -> single ci_start pulse, out_result 40400000, out_valid until out_ready.
REQ-033 Scenario 2: push 5 pairs back-to-back, DEPTH 4, out_ready held high -> in_ready low once full, 5 results in order, no lost or duplicate start.
REQ-034 Scenario 3: out_ready low for 20 cycles in HOLD with 2 pairs queued -> no ci_start until handshake, then ci_start on the next cycle.
REQ-035 Scenario 4: ci_done pulsed during ISSUE and in IDLE -> ignored, no spurious out_valid.
REQ-036 Scenario 5: reset asserted in WAIT with 3 pairs queued -> all outputs 0 asynchronously, in_ready 1, subsequent ci_done ignored.
REQ-037 Scenario 6 (FP_CI_ISSUER_TIMEOUT_EN, TIMEOUT_CYCLES=16): no ci_done -> out_result 7FC00000, timeout=1 after 16 WAIT cycles, next pair still issued.
